// File: rtl/shared_pin_pkg.sv
// Shared definitions for the shared-pin arbiter.
//   state_t             : arbiter FSM states (IDLE, GRANT)
//   DEFAULT_SYNC_STAGES : default synchronizer depth for raw board inputs
//   idx_w(n)            : $clog2(n) with a floor of 1, for index/counter widths
package shared_pin_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pin_sync.sv
// One-bit multi-flop synchronizer for a raw asynchronous input pin.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : raw asynchronous input
//   q   : synchronized copy of d, STAGES clk cycles later
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/shared_pin_arbiter.sv
// Shares one registered output pin between N_REQ raw input pins.
// Raw inputs are synchronized, then granted round-robin with a minimum hold
// time; the owner's synchronized level drives pin_out.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   req_in       : raw asynchronous request pins (high = request)
//   pin_out      : shared output pin, registered level of the owner's input
//   grant_valid  : a requester currently owns pin_out
//   grant_idx    : owner index, 0 when no grant
//   grant_onehot : owner one-hot, all-zero when no grant
// Handshake: there is no ready path; a request is simply a held level. A
// requester is served once its synchronized level is seen high by the
// round-robin pick, and it keeps the pin for at least HOLD_CYCLES cycles.
module shared_pin_arbiter
    import shared_pin_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_in,
    output logic                           pin_out,
    output logic                           grant_valid,
    output logic [idx_w(N_REQ)-1:0]        grant_idx,
    output logic [N_REQ-1:0]               grant_onehot
);

    localparam int IW = idx_w(N_REQ);
    localparam int HW = idx_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_RST  = IW'(N_REQ - 1);

    logic [N_REQ-1:0] req_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_sync
        pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_in[g]),
            .q   (req_s[g])
        );
    end

    // Round-robin pick: first set bit scanning last+1, last+2, ... with wrap.
    // The request vector is doubled so the scan never needs a modulo index.
    // Result is {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    last);
        logic [2*N_REQ-1:0] dbl;
        logic [IW:0]        res;
        dbl = {req, req};
        res = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!res[IW] && dbl[int'(last) + i]) begin
                res = {1'b1, IW'((int'(last) + i) % N_REQ)};
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [IW-1:0]    idx_d;
    logic             pin_d;
    logic [N_REQ-1:0] onehot_d;
    logic [N_REQ-1:0] others;
    logic [IW:0]      pick_all;
    logic [IW:0]      pick_oth;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        hold_d   = hold_q;
        idx_d    = grant_idx;
        pin_d    = 1'b0;
        onehot_d = '0;

        others            = req_s;
        others[grant_idx] = 1'b0;
        pick_all          = rr_pick(req_s, last_q);
        pick_oth          = rr_pick(others, last_q);

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (pick_all[IW]) begin
                    state_d = GRANT;
                    idx_d   = pick_all[IW-1:0];
                    last_d  = pick_all[IW-1:0];
                    hold_d  = HOLD_LOAD;
                    pin_d   = req_s[pick_all[IW-1:0]];
                end
            end
            GRANT: begin
                pin_d = req_s[grant_idx];
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (pick_oth[IW]) begin
                    // Direct handover, no idle cycle between owners.
                    idx_d  = pick_oth[IW-1:0];
                    last_d = pick_oth[IW-1:0];
                    hold_d = HOLD_LOAD;
                    pin_d  = req_s[pick_oth[IW-1:0]];
                end else if (!pin_out && !req_s[grant_idx]) begin
                    // Release only after pin_out has already shown the low
                    // level, so the pin falls one cycle before grant_valid.
                    state_d = IDLE;
                    idx_d   = '0;
                    pin_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (state_d == GRANT) begin
            onehot_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= LAST_RST;
            hold_q       <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            pin_out      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            grant_idx    <= idx_d;
            grant_onehot <= onehot_d;
            pin_out      <= pin_d;
        end
    end

    // The FSM state is visible directly as grant_valid.
    assign grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_shared_pin_arbiter.sv
module tb_shared_pin_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_in = 4'b0000;
    logic       pin_out;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;

    int n_checks = 0;
    int n_pass   = 0;

    shared_pin_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .pin_out      (pin_out),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    always #5 clk = ~clk;

    // Observed bundle: {valid, idx[1:0], onehot[3:0], pin}
    logic [7:0] obs;
    assign obs = {grant_valid, grant_idx, grant_onehot, pin_out};

    function automatic logic [7:0] exp_vec(input bit v, input int idx, input bit pin);
        logic [1:0] ei;
        logic [3:0] eo;
        ei = v ? 2'(idx) : 2'd0;
        eo = v ? 4'(1 << idx) : 4'd0;
        return {v, ei, eo, pin};
    endfunction

    // ---------------- reference model ----------------
    bit [3:0] m_s0, m_s1;
    int       m_owner;
    int       m_last;
    int       m_age;
    bit       m_pin;

    function automatic int rr(input bit [3:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0;
        m_owner = -1; m_last = N - 1; m_age = 0; m_pin = 1'b0;
    endtask

    task automatic model_edge();
        int       pick;
        bit [3:0] cand;
        if (m_owner < 0) begin
            if (m_s1 != 0) begin
                pick = rr(m_s1, m_last);
                m_owner = pick; m_last = pick; m_age = 1; m_pin = m_s1[pick];
            end else begin
                m_pin = 1'b0;
            end
        end else begin
            cand = m_s1;
            cand[m_owner] = 1'b0;
            if (m_age >= HOLD && cand != 0) begin
                pick = rr(cand, m_last);
                m_owner = pick; m_last = pick; m_age = 1; m_pin = m_s1[pick];
            end else if (m_age >= HOLD && !m_pin && !m_s1[m_owner]) begin
                m_owner = -1; m_pin = 1'b0;
            end else begin
                m_age++;
                m_pin = m_s1[m_owner];
            end
        end
        m_s1 = m_s0;
        m_s0 = req_in;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [3:0] req);
        req_in = req;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] e;
        req_in = 4'b1111;
        rst = 1'b1;
        #3;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_async got %h want %h", obs, 8'h00);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_held got %h want %h", obs, 8'h00);
        else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            e = (k < 3) ? 8'h00 : exp_vec(1'b1, 0, 1'b1);
            n_checks++;
            if (obs !== e) $display("FAIL reset_first_grant k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        do_reset(4'b0000);
        step();
        req_in = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = (k < 3) ? 8'h00 : exp_vec(1'b1, 1, 1'b1);
            n_checks++;
            if (obs !== e) $display("FAIL single k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        logic [7:0] e;
        do_reset(4'b0000);
        req_in = 4'b0101;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k < 3)       e = 8'h00;
            else if (k < 7)  e = exp_vec(1'b1, 0, 1'b1);
            else if (k < 11) e = exp_vec(1'b1, 2, 1'b1);
            else             e = exp_vec(1'b1, 0, 1'b1);
            n_checks++;
            if (obs !== e) $display("FAIL contention k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        logic [7:0] e;
        do_reset(4'b0000);
        req_in = 4'b1000;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 4) req_in = 4'b0000;
            if (k < 3)      e = 8'h00;
            else if (k < 7) e = exp_vec(1'b1, 3, 1'b1);
            else if (k < 8) e = exp_vec(1'b1, 3, 1'b0);
            else            e = 8'h00;
            n_checks++;
            if (obs !== e) $display("FAIL drop k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        do_reset(4'b0000);
        req_in = 4'b1000;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) req_in = 4'b1001;
            if (k < 3)       e = 8'h00;
            else if (k < 7)  e = exp_vec(1'b1, 3, 1'b1);
            else if (k < 11) e = exp_vec(1'b1, 0, 1'b1);
            else             e = exp_vec(1'b1, 3, 1'b1);
            n_checks++;
            if (obs !== e) $display("FAIL wrap k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        do_reset(4'b0000);
        req_in = 4'b0100;
        repeat (4) step();
        e = exp_vec(1'b1, 2, 1'b1);
        n_checks++;
        if (obs !== e) $display("FAIL async_pre got %h want %h", obs, e);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL async_clear got %h want %h", obs, 8'h00);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = (k < 3) ? 8'h00 : exp_vec(1'b1, 2, 1'b1);
            n_checks++;
            if (obs !== e) $display("FAIL async_reacquire k=%0d got %h want %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        int         hold_len;
        do_reset(4'b0000);
        model_reset();
        for (int seg = 0; seg < 40; seg++) begin
            req_in = 4'($urandom_range(0, 15));
            hold_len = $urandom_range(1, 10);
            for (int c = 0; c < hold_len; c++) begin
                @(posedge clk);
                model_edge();
                @(negedge clk);
                e = exp_vec(m_owner >= 0, (m_owner >= 0) ? m_owner : 0, m_pin);
                n_checks++;
                if (obs !== e) $display("FAIL random seg=%0d c=%0d got %h want %h", seg, c, obs, e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
